pipelined_dual_port_ram: RTL

//  Simple dual-port RAM (one write port, one read port, one clock), successor to the fixed two-latency

---
 rtl/riscv_mem_pkg.sv | 31 +++
 rtl/mem_read_pipe.sv | 40 ++++
 rtl/pipelined_dual_port_ram.sv | 121 ++++++++++++
 3 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared memory definitions for the RISC-V cache storage arrays.
// Read-during-write policy names, latency bound and byte-lane merge helper.
package riscv_mem_pkg;

  localparam string RDW_READ_FIRST  = "READ_FIRST";
  localparam string RDW_WRITE_FIRST = "WRITE_FIRST";

  localparam int MAX_READ_LATENCY = 4;

  // Widest word the merge helper handles.
  localparam int MERGE_W  = 1024;
  localparam int MERGE_IW = $clog2(MERGE_W);

  // Lane b of the result comes from new_w when be[b] is set,
  // otherwise from old_w. Lanes are bw bits wide.
  function automatic logic [MERGE_W-1:0] merge_bytes(
    input logic [MERGE_W-1:0] old_w,
    input logic [MERGE_W-1:0] new_w,
    input logic [MERGE_W-1:0] be,
    input int                 bw
  );
    logic [MERGE_W-1:0] r;
    r = old_w;
    for (int i = 0; i < MERGE_W; i++) begin
      if (be[MERGE_IW'(i / bw)])
        r[MERGE_IW'(i)] = new_w[MERGE_IW'(i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_read_pipe.sv
// Delay line for read data with a travelling valid bit.
// Ports: CLK, RST_N, in_data/in_valid -> out_data/out_valid after DEPTH edges.
module mem_read_pipe #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid
);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] vld_q;

  // Data registers only load behind a valid bit so the output
  // holds the last result while the pipe is idle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        data_q[i] <= '0;
    end else begin
      vld_q[0] <= in_valid;
      if (in_valid)
        data_q[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1])
          data_q[i] <= data_q[i-1];
      end
    end
  end

  assign out_data  = data_q[DEPTH-1];
  assign out_valid = vld_q[DEPTH-1];

endmodule

// File: rtl/pipelined_dual_port_ram.sv
// Simple dual-port RAM: byte-lane writes, 1..4 cycle pipelined reads.
// Ports: CLK, RST_N, WRITE_ADDRESS/DATA_IN/WRITE_ENABLE (write port),
//   READ_ADDRESS/READ_ENABLE (read port), DATA_OUT/DATA_OUT_VALID,
//   COLLISION (same-address read+write seen on the previous edge).
module pipelined_dual_port_ram
  import riscv_mem_pkg::*;
#(
  parameter int    MEMORY_WIDTH = 512,
  parameter int    MEMORY_DEPTH = 512,
  parameter int    BYTE_WIDTH   = 8,
  parameter int    READ_LATENCY = 1,
  parameter string RDW_MODE     = "READ_FIRST",
  parameter string INIT_FILE    = "",
  localparam int   ADDR_W       =
    (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1,
  localparam int   NUM_BYTES    = MEMORY_WIDTH / BYTE_WIDTH
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [ADDR_W-1:0]       WRITE_ADDRESS,
  input  logic [MEMORY_WIDTH-1:0] DATA_IN,
  input  logic [NUM_BYTES-1:0]    WRITE_ENABLE,
  input  logic [ADDR_W-1:0]       READ_ADDRESS,
  input  logic                    READ_ENABLE,
  output logic [MEMORY_WIDTH-1:0] DATA_OUT,
  output logic                    DATA_OUT_VALID,
  output logic                    COLLISION
);

  localparam bit FWD_WRITE = (RDW_MODE == RDW_WRITE_FIRST);

  localparam logic [ADDR_W:0] DEPTH_LIM =
    (ADDR_W+1)'(MEMORY_DEPTH);

  logic [MEMORY_WIDTH-1:0] mem [MEMORY_DEPTH];

  logic                    wr_any;
  logic                    wr_ok;
  logic                    rd_ok;
  logic                    rdw_hit;
  logic [MEMORY_WIDTH-1:0] rd_word;
  logic [MEMORY_WIDTH-1:0] rd_fwd;
  logic [MEMORY_WIDTH-1:0] s1_data;
  logic                    s1_valid;

  initial begin
    if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY)
      $error("READ_LATENCY must be 1..%0d", MAX_READ_LATENCY);
    if (MEMORY_WIDTH % BYTE_WIDTH != 0)
      $error("MEMORY_WIDTH must be a multiple of BYTE_WIDTH");
    if (RDW_MODE != RDW_READ_FIRST && RDW_MODE != RDW_WRITE_FIRST)
      $error("RDW_MODE must be READ_FIRST or WRITE_FIRST");
    if (MEMORY_WIDTH > MERGE_W)
      $error("MEMORY_WIDTH exceeds merge helper width");
    for (int i = 0; i < MEMORY_DEPTH; i++)
      mem[i] = '0;
  end

  assign wr_any  = |WRITE_ENABLE;
  assign wr_ok   = {1'b0, WRITE_ADDRESS} < DEPTH_LIM;
  assign rd_ok   = {1'b0, READ_ADDRESS} < DEPTH_LIM;
  assign rdw_hit = READ_ENABLE & wr_any &
                   (READ_ADDRESS == WRITE_ADDRESS);

  // Array is left unreset so it maps onto block RAM.
  always @(posedge CLK) begin
    if (RST_N && wr_ok) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (WRITE_ENABLE[b])
          mem[WRITE_ADDRESS][b*BYTE_WIDTH +: BYTE_WIDTH] <=
            DATA_IN[b*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  assign rd_word = rd_ok ? mem[READ_ADDRESS] : '0;

  // Write-first bypass: written lanes come straight from DATA_IN.
  always_comb begin
    rd_fwd = rd_word;
    if (FWD_WRITE && rdw_hit && rd_ok)
      rd_fwd = MEMORY_WIDTH'(merge_bytes(
        MERGE_W'(rd_word),
        MERGE_W'(DATA_IN),
        MERGE_W'(WRITE_ENABLE),
        BYTE_WIDTH));
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_data   <= '0;
      s1_valid  <= 1'b0;
      COLLISION <= 1'b0;
    end else begin
      s1_valid  <= READ_ENABLE;
      COLLISION <= rdw_hit;
      if (READ_ENABLE)
        s1_data <= rd_fwd;
    end
  end

  generate
    if (READ_LATENCY > 1) begin : g_pipe
      mem_read_pipe #(
        .WIDTH (MEMORY_WIDTH),
        .DEPTH (READ_LATENCY - 1)
      ) u_pipe (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .in_data   (s1_data),
        .in_valid  (s1_valid),
        .out_data  (DATA_OUT),
        .out_valid (DATA_OUT_VALID)
      );
    end else begin : g_direct
      assign DATA_OUT       = s1_data;
      assign DATA_OUT_VALID = s1_valid;
    end
  endgenerate

endmodule
